multi_digit_counter: RTL and testbench

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/multi_digit_counter.sv | 138 +++++++++++++
 tb/tb_multi_digit_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multi_digit_counter.sv
// multi_digit_counter
//
// Cascaded modulo-DIGIT_MOD counter made of NUM_DIGITS digits, each
// DIGIT_WIDTH bits wide, with digit 0 in the least significant bits.
// Carry and borrow ripple through every digit in a single cycle. When
// SATURATE is 0 the count wraps at either end of its range. When SATURATE
// is 1 the count holds at all-max or all-zero instead of wrapping.
//
// Build option:
//   MULTI_DIGIT_COUNTER_LOAD_EN  When defined, load/load_value perform a
//                                parallel load, and any digit value
//                                >= DIGIT_MOD is clamped to DIGIT_MOD-1.
//                                When undefined, both ports are kept but
//                                are ignored.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears every digit
//   increment      request one up-step this cycle
//   decrement      request one down-step this cycle
//   clear          synchronous clear of all digits
//   load           synchronous parallel load
//   load_value     load data, NUM_DIGITS*DIGIT_WIDTH bits
//   count          registered digit values
//   rolling_over   combinational: an up-step is taken while all digits are at max
//   rolling_under  combinational: a down-step is taken while all digits are zero
//   at_zero        combinational: all digits are zero

module multi_digit_counter #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_MOD   = 10,
    parameter int DIGIT_WIDTH = 4,
    parameter int SATURATE    = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              increment,
    input  logic                              decrement,
    input  logic                              clear,
    input  logic                              load,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] load_value,
    output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] count,
    output logic                              rolling_over,
    output logic                              rolling_under,
    output logic                              at_zero
);

    localparam logic [DIGIT_WIDTH-1:0] DIGIT_MAX = DIGIT_WIDTH'(DIGIT_MOD - 1);

    logic                  load_eff;
    logic                  up;
    logic                  down;
    logic                  all_max;
    logic                  all_zero;
    logic                  hold_sat;
    logic [NUM_DIGITS-1:0] is_max;
    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS-1:0] carry_in;
    logic [NUM_DIGITS-1:0] borrow_in;

`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
    assign load_eff = load;
`else
    // With loading compiled out, the load inputs are simply tied off.
    logic unused_load_sigs;
    assign unused_load_sigs = ^{load, load_value};
    assign load_eff         = 1'b0;
`endif

    // A step is taken only when exactly one direction is requested and
    // neither clear nor load applies this cycle.
    assign up   = increment & ~decrement & ~clear & ~load_eff;
    assign down = decrement & ~increment & ~clear & ~load_eff;

    assign all_max  = &is_max;
    assign all_zero = &is_zero;

    assign rolling_over  = ~reset & up & all_max;
    assign rolling_under = ~reset & down & all_zero;
    assign at_zero       = all_zero;

    // In saturating mode, an end-of-range step leaves the count unchanged.
    assign hold_sat = (SATURATE != 0) && ((up && all_max) || (down && all_zero));

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [DIGIT_WIDTH-1:0] digit_q;
        logic [DIGIT_WIDTH-1:0] step_val;

        assign is_max[k]  = (digit_q == DIGIT_MAX);
        assign is_zero[k] = (digit_q == '0);
        assign count[k*DIGIT_WIDTH +: DIGIT_WIDTH] = digit_q;

        // A digit moves only when every lower digit is at the wrap point
        // for the current direction.
        if (k == 0) begin : g_first
            assign carry_in[k]  = 1'b1;
            assign borrow_in[k] = 1'b1;
        end else begin : g_rest
            assign carry_in[k]  = carry_in[k-1] & is_max[k-1];
            assign borrow_in[k] = borrow_in[k-1] & is_zero[k-1];
        end

        always_comb begin
            step_val = digit_q;
            if (up && carry_in[k]) begin
                step_val = is_max[k] ? '0 : digit_q + 1'b1;
            end else if (down && borrow_in[k]) begin
                step_val = is_zero[k] ? DIGIT_MAX : digit_q - 1'b1;
            end
        end

`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
        logic [DIGIT_WIDTH-1:0] load_raw;
        logic [DIGIT_WIDTH-1:0] load_val;

        // The compare is one bit wider so that DIGIT_MOD = 2**DIGIT_WIDTH
        // still fits.
        assign load_raw = load_value[k*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign load_val = ({1'b0, load_raw} >= (DIGIT_WIDTH+1)'(DIGIT_MOD)) ?
                          DIGIT_MAX : load_raw;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                digit_q <= '0;
            end else if (clear) begin
                digit_q <= '0;
`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
            end else if (load_eff) begin
                digit_q <= load_val;
`endif
            end else if (!hold_sat) begin
                digit_q <= step_val;
            end
        end
    end

endmodule

// File: tb/tb_multi_digit_counter.sv
// tb_multi_digit_counter
//
// Drives one wrapping instance and one saturating instance of
// multi_digit_counter from the same inputs. Each directed vector pushes
// hand-computed expectations into a queue. A separate monitor pops each
// entry, checks the combinational flags before the clock edge, and checks
// the registered count after the edge.

module tb_multi_digit_counter;

`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
    localparam bit LOAD_ON = 1'b1;
`else
    localparam bit LOAD_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        increment;
    logic        decrement;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count_w, count_s;
    logic        ro_w, ru_w, az_w;
    logic        ro_s, ru_s, az_s;

    multi_digit_counter #(.NUM_DIGITS(4), .DIGIT_MOD(10), .DIGIT_WIDTH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .clear(clear), .load(load), .load_value(load_value), .count(count_w),
        .rolling_over(ro_w), .rolling_under(ru_w), .at_zero(az_w));

    multi_digit_counter #(.NUM_DIGITS(4), .DIGIT_MOD(10), .DIGIT_WIDTH(4), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .clear(clear), .load(load), .load_value(load_value), .count(count_s),
        .rolling_over(ro_s), .rolling_under(ru_s), .at_zero(az_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // flags are {rolling_over, rolling_under, at_zero}
    typedef struct {
        string       name;
        logic [2:0]  w_flags;
        logic [15:0] w_cnt;
        logic [2:0]  s_flags;
        logic [15:0] s_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: flags are sampled shortly before the rising edge, and the
    // count shortly after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, "/wrap_flags"}, {13'd0, ro_w, ru_w, az_w}, {13'd0, e.w_flags});
                check({e.name, "/sat_flags"},  {13'd0, ro_s, ru_s, az_s}, {13'd0, e.s_flags});
                @(posedge clk);
                #1;
                check({e.name, "/wrap_count"}, count_w, e.w_cnt);
                check({e.name, "/sat_count"},  count_s, e.s_cnt);
            end
        end
    end

    task automatic drive(input logic rst, input logic inc, input logic dec,
                         input logic clr, input logic ld, input logic [15:0] lv);
        reset      = rst;
        increment  = inc;
        decrement  = dec;
        clear      = clr;
        load       = ld;
        load_value = lv;
    endtask

    task automatic vec(input string name, input logic rst, input logic inc, input logic dec,
                       input logic clr, input logic ld, input logic [15:0] lv,
                       input logic [2:0] wf, input logic [15:0] wc,
                       input logic [2:0] sf, input logic [15:0] sc);
        exp_t e;
        @(negedge clk);
        #1;
        drive(rst, inc, dec, clr, ld, lv);
        e.name = name; e.w_flags = wf; e.w_cnt = wc; e.s_flags = sf; e.s_cnt = sc;
        exp_q.push_back(e);
    endtask

    task automatic run_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);

        //   name               rst inc dec clr ld  load_val  wrap flags/count    sat flags/count
        vec("reset_hold",       1, 1, 0, 0, 0, 16'h0000, 3'b001, 16'h0000, 3'b001, 16'h0000);
        vec("dec_at_zero",      0, 0, 1, 0, 0, 16'h0000, 3'b011, 16'h9999, 3'b011, 16'h0000);
        vec("inc_at_max",       0, 1, 0, 0, 0, 16'h0000, 3'b100, 16'h0000, 3'b001, 16'h0001);
        vec("reset_a",          1, 0, 0, 0, 0, 16'h0000, 3'b001, 16'h0000, 3'b000, 16'h0000);
        vec("reset_b",          1, 0, 0, 0, 0, 16'h0000, 3'b001, 16'h0000, 3'b001, 16'h0000);
        run_inc(999);
        vec("carry_0999",       0, 1, 0, 0, 0, 16'h0000, 3'b000, 16'h1000, 3'b000, 16'h1000);
        vec("borrow_1000",      0, 0, 1, 0, 0, 16'h0000, 3'b000, 16'h0999, 3'b000, 16'h0999);
        vec("reset_mid_carry",  1, 1, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 3'b000, 16'h0000);
        vec("post_reset_inc1",  0, 1, 0, 0, 0, 16'h0000, 3'b001, 16'h0001, 3'b001, 16'h0001);
        vec("post_reset_inc2",  0, 1, 0, 0, 0, 16'h0000, 3'b000, 16'h0002, 3'b000, 16'h0002);
        vec("post_reset_inc3",  0, 1, 0, 0, 0, 16'h0000, 3'b000, 16'h0003, 3'b000, 16'h0003);
        run_inc(497);
        vec("inc_and_dec",      0, 1, 1, 0, 0, 16'h0000, 3'b000, 16'h0500, 3'b000, 16'h0500);
        vec("clear_over_inc",   0, 1, 0, 1, 0, 16'h0000, 3'b000, 16'h0000, 3'b000, 16'h0000);
        run_inc(9999);
        vec("inc_at_max_sat",   0, 1, 0, 0, 0, 16'h0000, 3'b100, 16'h0000, 3'b100, 16'h9999);
        vec("dec_split",        0, 0, 1, 0, 0, 16'h0000, 3'b011, 16'h9999, 3'b000, 16'h9998);
        vec("clear",            0, 0, 0, 1, 0, 16'h0000, 3'b000, 16'h0000, 3'b000, 16'h0000);
        if (LOAD_ON) begin
            vec("load_with_inc",  0, 1, 0, 0, 1, 16'h12A4, 3'b001, 16'h1294, 3'b001, 16'h1294);
            vec("load_clamp",     0, 0, 0, 0, 1, 16'hFFFF, 3'b000, 16'h9999, 3'b000, 16'h9999);
            vec("inc_after_load", 0, 1, 0, 0, 0, 16'h0000, 3'b100, 16'h0000, 3'b100, 16'h9999);
            vec("load_vs_dec",    0, 0, 1, 0, 1, 16'h0000, 3'b001, 16'h0000, 3'b000, 16'h0000);
        end else begin
            vec("load_with_inc",  0, 1, 0, 0, 1, 16'h12A4, 3'b001, 16'h0001, 3'b001, 16'h0001);
            vec("load_clamp",     0, 0, 0, 0, 1, 16'hFFFF, 3'b000, 16'h0001, 3'b000, 16'h0001);
            vec("inc_after_load", 0, 1, 0, 0, 0, 16'h0000, 3'b000, 16'h0002, 3'b000, 16'h0002);
            vec("load_vs_dec",    0, 0, 1, 0, 1, 16'h0000, 3'b000, 16'h0001, 3'b000, 16'h0001);
        end

        @(negedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
